// File: rtl/rc_servo_pkg.sv
// Shared definitions for the RC servo PWM link: pulse-width landmarks,
// position width and the pulse decoder state encoding.
package rc_servo_pkg;

  localparam int RC_PULSE_MIN_POS_US = 1000;
  localparam int RC_PULSE_CENTER_US  = 1500;
  localparam int RC_PULSE_MAX_POS_US = 2000;
  localparam int POS_W               = 10;

  typedef enum logic [1:0] {
    ST_SYNC_LOW  = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } rc_dec_state_e;

endpackage

// File: rtl/rc_input_sync.sv
// Pad input conditioning for the RC PWM decoder: 2-FF synchronizer followed,
// when RC_PWM_DECODER_GLITCH_FILTER_EN is defined, by a glitch filter that only
// adopts a new level after FILTER_LEN consecutive identical samples.
module rc_input_sync
`ifdef RC_PWM_DECODER_GLITCH_FILTER_EN
#(
  parameter int FILTER_LEN = 4
)
`endif
(
  input  logic i_clk,
`ifdef RC_PWM_DECODER_GLITCH_FILTER_EN
  input  logic i_rst,
`endif
  input  logic i_async,
  output logic o_level
);

  logic r_meta_p0;
  logic r_sync_p1;

  // Two-flop synchronizer, left unreset so the pad level keeps flowing in during reset
  always_ff @(posedge i_clk) begin
    r_meta_p0 <= i_async;
    r_sync_p1 <= r_meta_p0;
  end

`ifdef RC_PWM_DECODER_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filt_p2;

  // Glitch filter: count consecutive samples that differ from the held level
  // and switch only on the FILTER_LEN-th; reset loads the current level so a
  // pulse already in progress at reset release is seen as high, not as a rise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_filt_p2 <= r_sync_p1;
    end else if (r_sync_p1 == r_filt_p2) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
      r_cnt     <= '0;
      r_filt_p2 <= r_sync_p1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_filt_p2;
`else
  assign o_level = r_sync_p1;
`endif

endmodule

// File: rtl/rc_pwm_pulse_decoder.sv
// RC servo PWM receiver: measures the high time of a hobby-servo pulse in us,
// converts 1000..2000 us into a 0..1000 position with a one-cycle valid strobe,
// flags out-of-range pulses and declares signal loss after TIMEOUT_US.
// Optional glitch filter: define RC_PWM_DECODER_GLITCH_FILTER_EN.
module rc_pwm_pulse_decoder
  import rc_servo_pkg::*;
#(
  parameter int CLKS_PER_US = 50,
  parameter int MIN_US      = 800,
  parameter int MAX_US      = 2200,
  parameter int TIMEOUT_US  = 25000
`ifdef RC_PWM_DECODER_GLITCH_FILTER_EN
  ,
  parameter int FILTER_LEN  = 4
`endif
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pwm_async_i,
  output logic [POS_W-1:0] position_o,
  output logic             position_valid_o,
  output logic             pulse_error_o,
  output logic             signal_lost_o
);

  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int WID_W = 12;
  localparam int TMO_W = 15;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_US - 1);
  localparam logic [WID_W-1:0] MIN_WID  = WID_W'(MIN_US);
  localparam logic [WID_W-1:0] MAX_WID  = WID_W'(MAX_US);
  localparam logic [WID_W-1:0] OVR_WID  = WID_W'(MAX_US + 1);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_US);
  localparam logic [POS_W-1:0] POS_CTR  = POS_W'(RC_PULSE_CENTER_US - RC_PULSE_MIN_POS_US);

  // Saturating width-to-position conversion: clamp below 1000 us and above 2000 us
  function automatic logic [POS_W-1:0] width_to_pos(input logic [WID_W-1:0] width_us);
    logic [WID_W-1:0] offset;
    offset = width_us - WID_W'(RC_PULSE_MIN_POS_US);
    if (width_us < WID_W'(RC_PULSE_MIN_POS_US)) return '0;
    if (width_us > WID_W'(RC_PULSE_MAX_POS_US))
      return POS_W'(RC_PULSE_MAX_POS_US - RC_PULSE_MIN_POS_US);
    return POS_W'(offset);
  endfunction

  logic             w_level;
  logic             r_lvl;
  logic             r_rise;
  logic             r_fall;
  logic [PRE_W-1:0] r_pre;
  logic             w_tick;
  rc_dec_state_e    r_state;
  logic [WID_W-1:0] r_width;
  logic [WID_W-1:0] w_width_next;
  logic             w_in_range;
  logic             w_accept;
  logic             w_reject;
  logic             w_overrun;
  logic [POS_W-1:0] r_pos;
  logic             r_pos_vld;
  logic             r_err;
  logic [TMO_W-1:0] r_tmo;
  logic             r_lost;

  rc_input_sync
`ifdef RC_PWM_DECODER_GLITCH_FILTER_EN
  #(
    .FILTER_LEN (FILTER_LEN)
  )
`endif
  u_input_sync (
    .i_clk   (clk_i),
`ifdef RC_PWM_DECODER_GLITCH_FILTER_EN
    .i_rst   (reset_i),
`endif
    .i_async (pwm_async_i),
    .o_level (w_level)
  );

  // Registered copy of the clean level; unreset so a level held through reset is not seen as an edge
  always_ff @(posedge clk_i) begin
    r_lvl <= w_level;
  end

  // Edge register: rise/fall strobes aligned with r_lvl
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_level & ~r_lvl;
      r_fall <= ~w_level & r_lvl;
    end
  end

  // us prescaler, re-phased on every rise so the measured width is exact to -1/+0 us
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pre <= '0;
    end else if (r_rise || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign w_tick       = (r_pre == PRE_LAST);
  assign w_width_next = r_width + {{(WID_W-1){1'b0}}, w_tick};
  assign w_in_range   = (w_width_next >= MIN_WID) && (w_width_next <= MAX_WID);
  assign w_accept     = (r_state == ST_MEASURE) && r_fall && w_in_range;
  assign w_reject     = (r_state == ST_MEASURE) && r_fall && !w_in_range;
  assign w_overrun    = (r_state == ST_MEASURE) && !r_fall && (w_width_next == OVR_WID);

  // Pulse measurement FSM with registered position, valid and error outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_SYNC_LOW;
      r_width   <= '0;
      r_pos     <= POS_CTR;
      r_pos_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_pos_vld <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        ST_SYNC_LOW: begin
          if (!r_lvl) r_state <= ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (r_rise) begin
            r_state <= ST_MEASURE;
            r_width <= '0;
          end
        end
        ST_MEASURE: begin
          r_width <= w_width_next;
          if (w_accept) begin
            r_pos     <= width_to_pos(w_width_next);
            r_pos_vld <= 1'b1;
            r_state   <= ST_WAIT_RISE;
          end else if (w_reject) begin
            r_err   <= 1'b1;
            r_state <= ST_WAIT_RISE;
          end else if (w_overrun) begin
            // still high past the longest legal pulse: drop it and resync on the low level
            r_err   <= 1'b1;
            r_state <= ST_SYNC_LOW;
          end
        end
        default: r_state <= ST_SYNC_LOW;
      endcase
    end
  end

  // Signal-loss timer in us: cleared by accepted pulses only, saturates at the limit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_tmo  <= '0;
      r_lost <= 1'b0;
    end else if (w_accept) begin
      r_tmo  <= '0;
      r_lost <= 1'b0;
    end else if (w_tick && (r_tmo != TMO_LIM)) begin
      r_tmo <= r_tmo + 1'b1;
      if ((r_tmo + 1'b1) == TMO_LIM) r_lost <= 1'b1;
    end
  end

  assign position_o       = r_pos;
  assign position_valid_o = r_pos_vld;
  assign pulse_error_o    = r_err;
  assign signal_lost_o    = r_lost;

endmodule

// File: tb/tb_rc_pwm_pulse_decoder.sv
// Directed bench for rc_pwm_pulse_decoder with a scaled clock (2 clk per us)
// and a shortened signal-loss timeout so the run stays short.
module tb_rc_pwm_pulse_decoder;

  localparam int CLK_US = 2;
  localparam int TMO_US = 8000;
  localparam int GAP    = 80;
`ifdef RC_PWM_DECODER_GLITCH_FILTER_EN
  localparam int FLT        = 4;
  localparam int SPIKE_ERRS = 0;
`else
  localparam int FLT        = 0;
  localparam int SPIKE_ERRS = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm = 1'b0;
  logic [9:0] position_o;
  logic       position_valid_o;
  logic       pulse_error_o;
  logic       signal_lost_o;

  int tot = 0;
  int bad = 0;

  int   n_vld = 0;
  int   n_err = 0;
  int   n_both = 0;
  int   cyc = 0;
  int   last_vld_cyc = 0;
  logic prev_lost = 1'b0;
  logic lost_at_vld = 1'b0;
  logic lost_before_vld = 1'b0;

  rc_pwm_pulse_decoder #(
    .CLKS_PER_US (CLK_US),
    .MIN_US      (800),
    .MAX_US      (2200),
    .TIMEOUT_US  (TMO_US)
  ) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .pwm_async_i      (pwm),
    .position_o       (position_o),
    .position_valid_o (position_valid_o),
    .pulse_error_o    (pulse_error_o),
    .signal_lost_o    (signal_lost_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (position_valid_o) begin
      n_vld           = n_vld + 1;
      last_vld_cyc    = cyc;
      lost_at_vld     = signal_lost_o;
      lost_before_vld = prev_lost;
    end
    if (pulse_error_o) n_err = n_err + 1;
    if (position_valid_o && pulse_error_o) n_both = n_both + 1;
    prev_lost = signal_lost_o;
  end

  task automatic send_pulse(input int us, output int lat);
    lat = -1;
    @(posedge clk); #1 pwm = 1'b1;
    repeat (us * CLK_US) @(posedge clk);
    #1 pwm = 1'b0;
    for (int i = 1; i <= GAP; i++) begin
      @(posedge clk); #1;
      if (lat < 0 && (position_valid_o || pulse_error_o)) lat = i;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pwm = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tot++; if (position_o !== 10'd500) begin bad++; $display("FAIL reset_pos got=%0d exp=500", position_o); end
    tot++; if (position_valid_o !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b exp=0", position_valid_o); end
    tot++; if (pulse_error_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", pulse_error_o); end
    tot++; if (signal_lost_o !== 1'b0) begin bad++; $display("FAIL reset_lost got=%0b exp=0", signal_lost_o); end
    rst = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_center;
    int v0, e0, lat;
    v0 = n_vld; e0 = n_err;
    send_pulse(1500, lat);
    tot++; if (n_vld - v0 !== 1) begin bad++; $display("FAIL center_vld_count got=%0d exp=1", n_vld - v0); end
    tot++; if (n_err - e0 !== 0) begin bad++; $display("FAIL center_err_count got=%0d exp=0", n_err - e0); end
    tot++; if (position_o !== 10'd500) begin bad++; $display("FAIL center_pos got=%0d exp=500", position_o); end
    tot++; if (lat !== 4 + FLT) begin bad++; $display("FAIL center_latency got=%0d exp=%0d", lat, 4 + FLT); end
    tot++; if (signal_lost_o !== 1'b0) begin bad++; $display("FAIL center_lost got=%0b exp=0", signal_lost_o); end
  endtask

  task automatic test_range;
    int widths[7]  = '{1000, 2000, 900, 2100, 1234, 800, 2200};
    int exp_pos[7] = '{0, 1000, 0, 1000, 234, 0, 1000};
    int v0, e0, lat;
    for (int k = 0; k < 7; k++) begin
      v0 = n_vld; e0 = n_err;
      send_pulse(widths[k], lat);
      tot++; if (n_vld - v0 !== 1) begin bad++; $display("FAIL range_vld_%0dus got=%0d exp=1", widths[k], n_vld - v0); end
      tot++; if (n_err - e0 !== 0) begin bad++; $display("FAIL range_err_%0dus got=%0d exp=0", widths[k], n_err - e0); end
      tot++; if (int'(position_o) !== exp_pos[k]) begin bad++; $display("FAIL range_pos_%0dus got=%0d exp=%0d", widths[k], position_o, exp_pos[k]); end
    end
  endtask

  task automatic test_short;
    int widths[2] = '{700, 799};
    int v0, e0, lat;
    for (int k = 0; k < 2; k++) begin
      v0 = n_vld; e0 = n_err;
      send_pulse(widths[k], lat);
      tot++; if (n_err - e0 !== 1) begin bad++; $display("FAIL short_err_%0dus got=%0d exp=1", widths[k], n_err - e0); end
      tot++; if (n_vld - v0 !== 0) begin bad++; $display("FAIL short_vld_%0dus got=%0d exp=0", widths[k], n_vld - v0); end
      tot++; if (position_o !== 10'd1000) begin bad++; $display("FAIL short_pos_%0dus got=%0d exp=1000", widths[k], position_o); end
    end
  endtask

  task automatic test_too_long;
    int v0, e0, err_at, lat;
    v0 = n_vld; e0 = n_err; err_at = -1;
    @(posedge clk); #1 pwm = 1'b1;
    for (int i = 1; i <= 2400 * CLK_US; i++) begin
      @(posedge clk); #1;
      if (err_at < 0 && pulse_error_o) err_at = i;
    end
    pwm = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    tot++; if (err_at !== 4 + 2201 * CLK_US + FLT) begin bad++; $display("FAIL long_err_time got=%0d exp=%0d", err_at, 4 + 2201 * CLK_US + FLT); end
    tot++; if (n_err - e0 !== 1) begin bad++; $display("FAIL long_err_count got=%0d exp=1", n_err - e0); end
    tot++; if (n_vld - v0 !== 0) begin bad++; $display("FAIL long_vld_count got=%0d exp=0", n_vld - v0); end
    tot++; if (position_o !== 10'd1000) begin bad++; $display("FAIL long_pos_kept got=%0d exp=1000", position_o); end
    v0 = n_vld;
    send_pulse(1200, lat);
    tot++; if (n_vld - v0 !== 1) begin bad++; $display("FAIL after_long_vld got=%0d exp=1", n_vld - v0); end
    tot++; if (position_o !== 10'd200) begin bad++; $display("FAIL after_long_pos got=%0d exp=200", position_o); end
  endtask

  task automatic test_reset_mid_pulse;
    int v0, e0, lat;
    @(posedge clk); #1 pwm = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    tot++; if (position_o !== 10'd500) begin bad++; $display("FAIL midrst_pos got=%0d exp=500", position_o); end
    v0 = n_vld; e0 = n_err;
    repeat (1000 * CLK_US) @(posedge clk);
    #1 pwm = 1'b0;
    repeat (GAP) @(posedge clk);
    send_pulse(1700, lat);
    tot++; if (n_vld - v0 !== 1) begin bad++; $display("FAIL midrst_vld_count got=%0d exp=1", n_vld - v0); end
    tot++; if (n_err - e0 !== 0) begin bad++; $display("FAIL midrst_err_count got=%0d exp=0", n_err - e0); end
    tot++; if (position_o !== 10'd700) begin bad++; $display("FAIL midrst_pos_after got=%0d exp=700", position_o); end
  endtask

  task automatic test_spikes;
    int v0, e0;
    v0 = n_vld; e0 = n_err;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 pwm = 1'b1;
      repeat (2) @(posedge clk);
      #1 pwm = 1'b0;
      repeat (40) @(posedge clk);
    end
    #1;
    tot++; if (n_err - e0 !== SPIKE_ERRS) begin bad++; $display("FAIL spike_err_count got=%0d exp=%0d", n_err - e0, SPIKE_ERRS); end
    tot++; if (n_vld - v0 !== 0) begin bad++; $display("FAIL spike_vld_count got=%0d exp=0", n_vld - v0); end
    tot++; if (position_o !== 10'd700) begin bad++; $display("FAIL spike_pos got=%0d exp=700", position_o); end
  endtask

  task automatic test_timeout;
    int lat, got;
    send_pulse(1500, lat);
    tot++; if (position_o !== 10'd500) begin bad++; $display("FAIL tmo_start_pos got=%0d exp=500", position_o); end
    while ((cyc - last_vld_cyc) < 4000 * CLK_US) @(posedge clk);
    send_pulse(700, lat);
    while ((cyc - last_vld_cyc) < (TMO_US - 40) * CLK_US) @(posedge clk);
    #1;
    tot++; if (signal_lost_o !== 1'b0) begin bad++; $display("FAIL tmo_early_lost got=%0b exp=0", signal_lost_o); end
    got = 0;
    for (int i = 0; i < 200 * CLK_US; i++) begin
      @(posedge clk); #1;
      if (signal_lost_o) got = 1;
    end
    tot++; if (got !== 1) begin bad++; $display("FAIL tmo_lost_set got=%0d exp=1", got); end
    repeat (500 * CLK_US) @(posedge clk);
    #1;
    tot++; if (signal_lost_o !== 1'b1) begin bad++; $display("FAIL tmo_lost_hold got=%0b exp=1", signal_lost_o); end
    send_pulse(1800, lat);
    tot++; if (position_o !== 10'd800) begin bad++; $display("FAIL tmo_recover_pos got=%0d exp=800", position_o); end
    tot++; if (lost_at_vld !== 1'b0) begin bad++; $display("FAIL tmo_lost_at_vld got=%0b exp=0", lost_at_vld); end
    tot++; if (lost_before_vld !== 1'b1) begin bad++; $display("FAIL tmo_lost_before_vld got=%0b exp=1", lost_before_vld); end
    tot++; if (signal_lost_o !== 1'b0) begin bad++; $display("FAIL tmo_lost_after got=%0b exp=0", signal_lost_o); end
  endtask

  initial begin
    test_reset();
    test_center();
    test_range();
    test_short();
    test_too_long();
    test_reset_mid_pulse();
    test_spikes();
    test_timeout();
    tot++; if (n_both !== 0) begin bad++; $display("FAIL vld_err_overlap got=%0d exp=0", n_both); end
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
